// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: N-stage operand forwarding, load-use and MUL
// scoreboard stalls, and the LL/SC link tracker that gates SC stores.
module id_hazard_ctrl #(
    parameter int DATA_W   = 32,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic                      id_flush,
    input  logic [4:0]                rs_addr,
    input  logic [4:0]                rt_addr,
    input  logic                      rs_used,
    input  logic                      rt_used,
    input  logic [DATA_W-1:0]         rs_rf,
    input  logic [DATA_W-1:0]         rt_rf,
    input  logic [4:0]                dst_addr,
    input  logic                      dst_we,
    input  logic                      is_mul,
    input  logic                      is_ll,
    input  logic                      is_sc,
    input  logic                      is_store,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [5*NUM_FWD-1:0]      fwd_addr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    output logic [DATA_W-1:0]         rs_data,
    output logic [DATA_W-1:0]         rt_data,
    output logic                      stall,
    output logic                      atomic_id,
    output logic                      mem_sc_mask_id
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    // The counter holds the remaining wait, so it reads 0 exactly MUL_LAT cycles after issue.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              load_use;
    } fwd_res_t;

    typedef enum logic {
        LINK_IDLE   = 1'b0,
        LINK_LINKED = 1'b1
    } link_state_e;

    fwd_res_t          rs_fwd_s;
    fwd_res_t          rt_fwd_s;
    logic [31:0]       busy_s;
    logic [CNT_W-1:0]  cnt_r [1:31];
    logic              load_use_s;
    logic              sb_hazard_s;
    logic              stall_s;
    logic              fire_s;
    logic              mul_set_s;
    link_state_e       state_r;
    link_state_e       state_nxt_s;

    // Walk stages oldest to youngest so the youngest matching stage overrides.
    function automatic fwd_res_t resolve_src(
        input logic [4:0]                src,
        input logic [DATA_W-1:0]         rf,
        input logic [NUM_FWD-1:0]        we,
        input logic [5*NUM_FWD-1:0]      addr,
        input logic [DATA_W*NUM_FWD-1:0] data,
        input logic [NUM_FWD-1:0]        is_load
    );
        fwd_res_t res;
        logic     hit;
        res.data     = rf;
        res.load_use = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            hit          = we[i] && (addr[5*i +: 5] == src) && (src != 5'd0);
            res.data     = hit ? data[DATA_W*i +: DATA_W] : res.data;
            res.load_use = hit ? (is_load[i] && (i < LOAD_LAT)) : res.load_use;
        end
        return res;
    endfunction

    // Operand forwarding for both sources.
    always_comb begin
        rs_fwd_s = resolve_src(rs_addr, rs_rf, fwd_we, fwd_addr, fwd_data, fwd_is_load);
        rt_fwd_s = resolve_src(rt_addr, rt_rf, fwd_we, fwd_addr, fwd_data, fwd_is_load);
        rs_data  = rs_fwd_s.data;
        rt_data  = rt_fwd_s.data;
    end

    // Busy map from the scoreboard; r0 can never be busy.
    always_comb begin
        busy_s[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            busy_s[r] = (cnt_r[r] != CNT_ZERO);
        end
    end

    // Stall and issue decisions.
    always_comb begin
        load_use_s  = (rs_used & rs_fwd_s.load_use) | (rt_used & rt_fwd_s.load_use);
        sb_hazard_s = (rs_used & busy_s[rs_addr]) | (rt_used & busy_s[rt_addr])
                    | (dst_we & busy_s[dst_addr]);
        stall_s     = id_valid & (load_use_s | sb_hazard_s);
        fire_s      = id_valid & ~stall_s & ~id_flush;
        mul_set_s   = fire_s & is_mul & dst_we & (dst_addr != 5'd0);
        stall       = stall_s;
    end

    // MUL scoreboard: load on issue, otherwise count down to zero every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (mul_set_s && (dst_addr == 5'(r))) begin
                    cnt_r[r] <= CNT_LOAD;
                end else if (cnt_r[r] != CNT_ZERO) begin
                    cnt_r[r] <= cnt_r[r] - CNT_ONE;
                end else begin
                    cnt_r[r] <= CNT_ZERO;
                end
            end
        end
    end

    // Link state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LINK_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Link next state; only an issuing instruction may change it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LINK_IDLE: begin
                if (fire_s && is_ll) begin
                    state_nxt_s = LINK_LINKED;
                end else begin
                    state_nxt_s = LINK_IDLE;
                end
            end
            LINK_LINKED: begin
                if (fire_s && (is_sc || is_store)) begin
                    state_nxt_s = LINK_IDLE;
                end else begin
                    state_nxt_s = LINK_LINKED;
                end
            end
            default: state_nxt_s = LINK_IDLE;
        endcase
    end

    // Link outputs; the SC mask uses the link as it stands before this instruction.
    always_comb begin
        atomic_id      = 1'b0;
        mem_sc_mask_id = 1'b0;
        case (state_r)
            LINK_IDLE: begin
                atomic_id      = 1'b0;
                mem_sc_mask_id = id_valid & is_sc;
            end
            LINK_LINKED: begin
                atomic_id      = 1'b1;
                mem_sc_mask_id = 1'b0;
            end
            default: begin
                atomic_id      = 1'b0;
                mem_sc_mask_id = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized cycles against a timestamp-based model.
module tb_id_hazard_ctrl;

    localparam int DW = 32;
    localparam int NF = 2;
    localparam int LL = 1;
    localparam int ML = 4;

    typedef struct packed {
        logic           rst;
        logic           valid;
        logic           flush;
        logic [4:0]     rs;
        logic [4:0]     rt;
        logic           rs_used;
        logic           rt_used;
        logic [DW-1:0]  rs_rf;
        logic [DW-1:0]  rt_rf;
        logic [4:0]     dst;
        logic           dst_we;
        logic           is_mul;
        logic           is_ll;
        logic           is_sc;
        logic           is_store;
        logic [NF-1:0]  fwd_we;
        logic [5*NF-1:0] fwd_addr;
        logic [DW*NF-1:0] fwd_data;
        logic [NF-1:0]  fwd_is_load;
    } in_t;

    typedef struct {
        in_t         i;
        logic [31:0] rs;
        logic        st;
        logic        at;
        logic        mk;
        string       nm;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            id_valid, id_flush;
    logic [4:0]      rs_addr, rt_addr, dst_addr;
    logic            rs_used, rt_used, dst_we, is_mul, is_ll, is_sc, is_store;
    logic [DW-1:0]   rs_rf, rt_rf, rs_data, rt_data;
    logic [NF-1:0]   fwd_we, fwd_is_load;
    logic [5*NF-1:0] fwd_addr;
    logic [DW*NF-1:0] fwd_data;
    logic            stall, atomic_id, mem_sc_mask_id;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned ready [32];
    bit          link_m = 1'b0;
    vec_t        tbl [$];

    id_hazard_ctrl #(.DATA_W(DW), .NUM_FWD(NF), .LOAD_LAT(LL), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
        .rs_rf(rs_rf), .rt_rf(rt_rf), .dst_addr(dst_addr), .dst_we(dst_we),
        .is_mul(is_mul), .is_ll(is_ll), .is_sc(is_sc), .is_store(is_store),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .atomic_id(atomic_id),
        .mem_sc_mask_id(mem_sc_mask_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic in_t base(input logic [4:0] rs, input logic [4:0] rt);
        in_t v;
        v = '0;
        v.valid   = 1'b1;
        v.rs_used = 1'b1;
        v.rt_used = 1'b1;
        v.rs      = rs;
        v.rt      = rt;
        v.rs_rf   = 32'hA000_0000;
        v.rt_rf   = 32'hB000_0000;
        return v;
    endfunction

    function automatic in_t fw(input in_t vi, input int s, input logic [4:0] a,
                               input logic [31:0] d, input logic ld);
        in_t v;
        v = vi;
        v.fwd_we[s]           = 1'b1;
        v.fwd_addr[5*s +: 5]  = a;
        v.fwd_data[DW*s +: DW] = d;
        v.fwd_is_load[s]      = ld;
        return v;
    endfunction

    // Reference forwarding: first (youngest) producing stage of a nonzero register.
    task automatic model_fwd(input in_t v, input logic [4:0] src, input logic [31:0] rf,
                             output logic [31:0] d, output logic lu);
        bit found;
        found = 1'b0;
        d = rf;
        lu = 1'b0;
        for (int s = 0; s < NF; s++) begin
            if (!found && src != 5'd0 && v.fwd_we[s] && v.fwd_addr[5*s +: 5] == src) begin
                found = 1'b1;
                d  = v.fwd_data[DW*s +: DW];
                lu = v.fwd_is_load[s] && (s < LL);
            end
        end
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready[r]);
    endfunction

    task automatic run(input vec_t e, input bit has_exp);
        logic [31:0] m_rs, m_rt;
        logic        lu_rs, lu_rt, m_st, m_at, m_mk, m_fire;
        rst = e.i.rst;       id_valid = e.i.valid;   id_flush = e.i.flush;
        rs_addr = e.i.rs;    rt_addr = e.i.rt;       rs_used = e.i.rs_used;
        rt_used = e.i.rt_used; rs_rf = e.i.rs_rf;    rt_rf = e.i.rt_rf;
        dst_addr = e.i.dst;  dst_we = e.i.dst_we;    is_mul = e.i.is_mul;
        is_ll = e.i.is_ll;   is_sc = e.i.is_sc;      is_store = e.i.is_store;
        fwd_we = e.i.fwd_we; fwd_addr = e.i.fwd_addr; fwd_data = e.i.fwd_data;
        fwd_is_load = e.i.fwd_is_load;
        @(negedge clk);
        model_fwd(e.i, e.i.rs, e.i.rs_rf, m_rs, lu_rs);
        model_fwd(e.i, e.i.rt, e.i.rt_rf, m_rt, lu_rt);
        m_st = e.i.valid & ((e.i.rs_used & (lu_rs | m_busy(e.i.rs)))
                          | (e.i.rt_used & (lu_rt | m_busy(e.i.rt)))
                          | (e.i.dst_we & m_busy(e.i.dst)));
        m_at = link_m;
        m_mk = e.i.valid & e.i.is_sc & ~link_m;
        chk($sformatf("%s.model_rs", e.nm), rs_data, m_rs);
        chk($sformatf("%s.model_rt", e.nm), rt_data, m_rt);
        chk($sformatf("%s.model_stall", e.nm), {31'd0, stall}, {31'd0, m_st});
        chk($sformatf("%s.model_atomic", e.nm), {31'd0, atomic_id}, {31'd0, m_at});
        chk($sformatf("%s.model_mask", e.nm), {31'd0, mem_sc_mask_id}, {31'd0, m_mk});
        if (has_exp) begin
            chk($sformatf("%s.rs", e.nm), rs_data, e.rs);
            chk($sformatf("%s.stall", e.nm), {31'd0, stall}, {31'd0, e.st});
            chk($sformatf("%s.atomic", e.nm), {31'd0, atomic_id}, {31'd0, e.at});
            chk($sformatf("%s.mask", e.nm), {31'd0, mem_sc_mask_id}, {31'd0, e.mk});
        end
        m_fire = e.i.valid & ~m_st & ~e.i.flush;
        @(posedge clk);
        if (e.i.rst) begin
            for (int r = 0; r < 32; r++) ready[r] = 0;
            link_m = 1'b0;
        end else begin
            if (m_fire && e.i.is_mul && e.i.dst_we && e.i.dst != 5'd0)
                ready[e.i.dst] = cyc + ML;
            if (m_fire && e.i.is_ll) link_m = 1'b1;
            if (m_fire && (e.i.is_sc || e.i.is_store)) link_m = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic add(input in_t v, input logic [31:0] rs, input logic st, input logic at,
                       input logic mk, input string nm);
        vec_t e;
        e.i = v; e.rs = rs; e.st = st; e.at = at; e.mk = mk; e.nm = nm;
        tbl.push_back(e);
    endtask

    task automatic step(input in_t v, input logic [31:0] rs, input logic st, input logic at,
                        input logic mk, input string nm);
        vec_t e;
        e.i = v; e.rs = rs; e.st = st; e.at = at; e.mk = mk; e.nm = nm;
        run(e, 1'b1);
    endtask

    initial begin
        in_t v;
        vec_t e;
        int k;
        for (int r = 0; r < 32; r++) ready[r] = 0;
        v = '0;
        rst = 1'b1; id_valid = 1'b0; id_flush = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
        rs_used = 1'b0; rt_used = 1'b0; rs_rf = '0; rt_rf = '0; dst_addr = 5'd0;
        dst_we = 1'b0; is_mul = 1'b0; is_ll = 1'b0; is_sc = 1'b0; is_store = 1'b0;
        fwd_we = '0; fwd_addr = '0; fwd_data = '0; fwd_is_load = '0;
        repeat (3) @(posedge clk);
        #1;

        add(base(5'd5, 5'd6), 32'hA000_0000, 1'b0, 1'b0, 1'b0, "reset_state");
        add(fw(base(5'd5, 5'd6), 0, 5'd5, 32'h1234, 1'b1), 32'h1234, 1'b1, 1'b0, 1'b0, "load_use");
        add(fw(base(5'd5, 5'd6), 1, 5'd5, 32'hCAFE, 1'b1), 32'hCAFE, 1'b0, 1'b0, 1'b0, "fwd_stage1");
        add(fw(fw(base(5'd3, 5'd0), 0, 5'd3, 32'h11, 1'b0), 1, 5'd3, 32'h22, 1'b0),
            32'h11, 1'b0, 1'b0, 1'b0, "youngest_wins");
        add(fw(base(5'd0, 5'd0), 0, 5'd0, 32'hFF, 1'b1), 32'hA000_0000, 1'b0, 1'b0, 1'b0, "r0_no_fwd");
        v = fw(base(5'd4, 5'd0), 0, 5'd4, 32'h44, 1'b1); v.rs_used = 1'b0;
        add(v, 32'h44, 1'b0, 1'b0, 1'b0, "unused_load");
        v = fw(base(5'd5, 5'd0), 0, 5'd5, 32'h55, 1'b1); v.is_ll = 1'b1;
        add(v, 32'h55, 1'b1, 1'b0, 1'b0, "ll_stalled");
        v = base(5'd0, 5'd0); v.is_ll = 1'b1; v.flush = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "ll_flushed");
        v = base(5'd0, 5'd0); v.is_ll = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "ll");
        v = base(5'd0, 5'd0); v.is_sc = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b1, 1'b0, "sc_linked");
        v = base(5'd0, 5'd0); v.is_sc = 1'b1; v.valid = 1'b0;
        add(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "after_sc");
        v = base(5'd0, 5'd0); v.is_ll = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "ll2");
        v = base(5'd0, 5'd0); v.is_store = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b1, 1'b0, "sw");
        v = base(5'd0, 5'd0); v.is_sc = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b0, 1'b1, "sc_masked");
        v = base(5'd0, 5'd0); v.is_mul = 1'b1; v.dst = 5'd10; v.dst_we = 1'b1; v.flush = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "mul_flushed");
        add(base(5'd10, 5'd0), 32'hA000_0000, 1'b0, 1'b0, 1'b0, "read_r10");
        v = base(5'd0, 5'd0); v.is_ll = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "ll3");
        v = fw(base(5'd5, 5'd0), 0, 5'd5, 32'h66, 1'b1); v.is_sc = 1'b1;
        add(v, 32'h66, 1'b1, 1'b1, 1'b0, "sc_stalled");
        v = base(5'd0, 5'd0); v.valid = 1'b0;
        add(v, 32'hA000_0000, 1'b0, 1'b1, 1'b0, "idle_linked");
        v = base(5'd0, 5'd0); v.is_sc = 1'b1; v.flush = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b1, 1'b0, "sc_flushed");
        v = base(5'd0, 5'd0); v.is_sc = 1'b1;
        add(v, 32'hA000_0000, 1'b0, 1'b1, 1'b0, "sc_ok");
        add(base(5'd0, 5'd0), 32'hA000_0000, 1'b0, 1'b0, 1'b0, "unlinked");
        for (int n = 0; n < tbl.size(); n++) run(tbl[n], 1'b1);

        // MUL r7 issue, RAW and WAW stalls for MUL_LAT-1 cycles, release on the 4th.
        v = base(5'd1, 5'd2); v.is_mul = 1'b1; v.dst = 5'd7; v.dst_we = 1'b1;
        step(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "mul_t0");
        step(base(5'd7, 5'd0), 32'hA000_0000, 1'b1, 1'b0, 1'b0, "mul_raw_t1");
        v = base(5'd1, 5'd2); v.dst = 5'd7; v.dst_we = 1'b1;
        step(v, 32'hA000_0000, 1'b1, 1'b0, 1'b0, "mul_waw_t2");
        step(base(5'd1, 5'd7), 32'hA000_0000, 1'b1, 1'b0, 1'b0, "mul_raw_t3");
        step(base(5'd7, 5'd0), 32'hA000_0000, 1'b0, 1'b0, 1'b0, "mul_free_t4");

        // Reset with a pending MUL and a live link.
        v = base(5'd0, 5'd0); v.is_ll = 1'b1;
        step(v, 32'hA000_0000, 1'b0, 1'b0, 1'b0, "rst_ll");
        v = base(5'd0, 5'd0); v.is_mul = 1'b1; v.dst = 5'd9; v.dst_we = 1'b1;
        step(v, 32'hA000_0000, 1'b0, 1'b1, 1'b0, "rst_mul");
        v = base(5'd9, 5'd0); v.rst = 1'b1;
        step(v, 32'hA000_0000, 1'b1, 1'b1, 1'b0, "rst_pulse");
        step(base(5'd9, 5'd0), 32'hA000_0000, 1'b0, 1'b0, 1'b0, "rst_after");

        for (int n = 0; n < 600; n++) begin
            v = '0;
            v.rst     = ($urandom_range(0, 63) == 0);
            v.valid   = ($urandom_range(0, 7) != 0);
            v.flush   = ($urandom_range(0, 7) == 0);
            v.rs      = 5'($urandom_range(0, 7));
            v.rt      = 5'($urandom_range(0, 7));
            v.rs_used = 1'($urandom_range(0, 1));
            v.rt_used = 1'($urandom_range(0, 1));
            v.rs_rf   = $urandom;
            v.rt_rf   = $urandom;
            v.dst     = 5'($urandom_range(0, 7));
            k = $urandom_range(0, 9);
            v.is_mul   = (k < 2);
            v.is_ll    = (k == 2);
            v.is_sc    = (k == 3);
            v.is_store = (k == 4);
            v.dst_we   = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int s = 0; s < NF; s++) begin
                v.fwd_we[s]            = 1'($urandom_range(0, 1));
                v.fwd_addr[5*s +: 5]   = 5'($urandom_range(0, 7));
                v.fwd_data[DW*s +: DW] = $urandom;
                v.fwd_is_load[s]       = ($urandom_range(0, 3) == 0);
            end
            e.i = v; e.rs = 32'd0; e.st = 1'b0; e.at = 1'b0; e.mk = 1'b0; e.nm = "rnd";
            run(e, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
